// File: rtl/decode_stage_if.sv
// Handshake and data bundle between fetch/regfile, the decode stage and its consumer.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_S;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic [2:0]  out_kind;
    logic [31:0] out_store_data;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, in_rs1, in_rs2, out_valid, out_S, out_A, out_B, out_rd, out_wb,
               out_kind, out_store_data, out_target, out_link, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, in_rs1, in_rs2, out_valid, out_S, out_A, out_B, out_rd, out_wb,
               out_kind, out_store_data, out_target, out_link, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+optional M) decode stage: combinational decode into a single-entry output register.
module decode_stage #(
    parameter int ENABLE_RV32_M = 0
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [2:0] K_ALU    = 3'd0;
    localparam logic [2:0] K_LOAD   = 3'd1;
    localparam logic [2:0] K_STORE  = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_JUMP   = 3'd4;
    localparam logic [2:0] K_MULDIV = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins   = bus.in_instr;
    assign opc   = ins[6:0];
    assign rd    = ins[11:7];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    assign bus.in_rs1 = ins[19:15];
    assign bus.in_rs2 = ins[24:20];

    logic [5:0]  d_s;
    logic [31:0] d_a, d_b, d_sd, d_tgt;
    logic [2:0]  d_kind;
    logic        d_wr, d_ill, d_wb;

    always_comb begin
        d_s    = '0;
        d_a    = '0;
        d_b    = '0;
        d_sd   = '0;
        d_tgt  = '0;
        d_kind = K_ALU;
        d_wr   = 1'b0;
        d_ill  = 1'b0;
        case (opc)
            OPC_OP: begin
                d_a = bus.in_rs1_data;
                d_b = bus.in_rs2_data;
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    d_s   = {f7[5], f3, 1'b0, f3 == 3'b000};
                    d_wr  = 1'b1;
                    // only SUB and SRA carry the alternate-op bit
                    d_ill = f7[5] && !(f3 == 3'b000 || f3 == 3'b101);
                end else if (f7 == 7'b0000001 && ENABLE_RV32_M != 0) begin
                    d_s    = {f3, 3'b000};
                    d_kind = K_MULDIV;
                    d_wr   = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                d_s   = {f3 == 3'b101 && f7[5], f3, 2'b00};
                d_a   = bus.in_rs1_data;
                d_b   = imm_i;
                d_wr  = 1'b1;
                d_ill = (f3 == 3'b001 && f7 != 7'b0000000) ||
                        (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            OPC_BRANCH: begin
                d_s    = {1'b0, f3, 2'b11};
                d_a    = bus.in_rs1_data;
                d_b    = bus.in_rs2_data;
                d_tgt  = bus.in_pc + imm_b;
                d_kind = K_BRANCH;
                d_ill  = (f3 == 3'b010 || f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_a    = bus.in_rs1_data;
                d_b    = imm_i;
                d_kind = K_LOAD;
                d_wr   = 1'b1;
            end
            OPC_STORE: begin
                d_a    = bus.in_rs1_data;
                d_b    = imm_s;
                d_sd   = bus.in_rs2_data;
                d_kind = K_STORE;
            end
            OPC_LUI: begin
                d_b  = imm_u;
                d_wr = 1'b1;
            end
            OPC_AUIPC: begin
                d_a  = bus.in_pc;
                d_b  = imm_u;
                d_wr = 1'b1;
            end
            OPC_JAL: begin
                d_tgt  = bus.in_pc + imm_j;
                d_kind = K_JUMP;
                d_wr   = 1'b1;
            end
            OPC_JALR: begin
                d_a    = bus.in_rs1_data;
                d_b    = imm_i;
                d_kind = K_JUMP;
                d_wr   = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign d_wb = d_wr && (rd != 5'd0) && !d_ill;

    logic xfer;
    assign bus.in_ready = !rst && !bus.flush && (!bus.out_valid || bus.out_ready);
    assign xfer         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_S          <= '0;
            bus.out_A          <= '0;
            bus.out_B          <= '0;
            bus.out_rd         <= '0;
            bus.out_wb         <= 1'b0;
            bus.out_kind       <= '0;
            bus.out_store_data <= '0;
            bus.out_target     <= '0;
            bus.out_link       <= '0;
            bus.out_illegal    <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (xfer) begin
            bus.out_valid      <= 1'b1;
            bus.out_S          <= d_s;
            bus.out_A          <= d_a;
            bus.out_B          <= d_b;
            bus.out_rd         <= rd;
            bus.out_wb         <= d_wb;
            bus.out_kind       <= d_kind;
            bus.out_store_data <= d_sd;
            bus.out_target     <= d_tgt;
            bus.out_link       <= bus.in_pc + 32'd4;
            bus.out_illegal    <= d_ill;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage; a second instance with RV32M enabled shadows the first.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if b0 ();
    decode_stage_if b1 ();

    assign b1.in_valid    = b0.in_valid;
    assign b1.in_instr    = b0.in_instr;
    assign b1.in_pc       = b0.in_pc;
    assign b1.in_rs1_data = b0.in_rs1_data;
    assign b1.in_rs2_data = b0.in_rs2_data;
    assign b1.flush       = b0.flush;
    assign b1.out_ready   = b0.out_ready;

    decode_stage #(.ENABLE_RV32_M(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    decode_stage #(.ENABLE_RV32_M(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct packed {
        logic [5:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic [2:0]  kind;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [31:0] link;
        logic        ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        exp_t  m;
        string tag;
        logic  chk1;
        exp_t  e1;
    } ent_t;

    ent_t sbq[$];
    ent_t nxt;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t snap;
    exp_t all_m;
    exp_t ill_m;
    exp_t jal_m;

    function automatic exp_t mk(logic [5:0] s, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                                logic wb, logic [2:0] kind, logic [31:0] sd, logic [31:0] tgt,
                                logic [31:0] link, logic ill);
        exp_t x;
        x = '{s: s, a: a, b: b, rd: rd, wb: wb, kind: kind, sd: sd, tgt: tgt, link: link, ill: ill};
        return x;
    endfunction

    function automatic exp_t cur0();
        return mk(b0.out_S, b0.out_A, b0.out_B, b0.out_rd, b0.out_wb, b0.out_kind,
                  b0.out_store_data, b0.out_target, b0.out_link, b0.out_illegal);
    endfunction

    function automatic exp_t cur1();
        return mk(b1.out_S, b1.out_A, b1.out_B, b1.out_rd, b1.out_wb, b1.out_kind,
                  b1.out_store_data, b1.out_target, b1.out_link, b1.out_illegal);
    endfunction

    task automatic chk(input string tag, input exp_t obs, input exp_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input string tag, input exp_t e, input exp_t m);
        b0.in_instr    = ins;
        b0.in_pc       = pc;
        b0.in_rs1_data = r1;
        b0.in_rs2_data = r2;
        nxt.e    = e;
        nxt.m    = m;
        nxt.tag  = tag;
        nxt.chk1 = 1'b0;
        nxt.e1   = '0;
    endtask

    // One clock: drive, sample on the falling edge, score both sides of the handshake.
    task automatic cyc(input logic v, input logic ordy, input logic fl, input int rdy_exp);
        ent_t x;
        b0.in_valid  = v;
        b0.out_ready = ordy;
        b0.flush     = fl;
        @(negedge clk);
        if (rdy_exp >= 0) chkv({"in_ready_", nxt.tag}, 32'(b0.in_ready), 32'(rdy_exp));
        if (b0.out_valid && b0.out_ready) begin
            if (sbq.size() == 0) begin
                chkv("unexpected_output", 32'd1, 32'd0);
            end else begin
                x = sbq.pop_front();
                chk(x.tag, cur0() & x.m, x.e & x.m);
                if (x.chk1) chk({x.tag, "_m_on"}, cur1(), x.e1);
            end
        end
        if (fl && b0.out_valid && sbq.size() > 0) void'(sbq.pop_front());
        if (v && b0.in_ready) sbq.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        all_m = '1;
        ill_m = '0;
        ill_m.wb  = 1'b1;
        ill_m.ill = 1'b1;
        jal_m = '1;
        jal_m.s = '0;
        jal_m.a = '0;
        jal_m.b = '0;

        // reset: input offered but never taken, outputs cleared
        rst = 1'b1;
        set(32'h002081B3, 32'h100, 5, 7, "rst", '0, all_m);
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("rst_outputs", cur0(), '0);
        chkv("rst_valid", 32'(b0.out_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        rst = 1'b0;

        // ADD x3,x1,x2 with one-cycle latency
        set(32'h002081B3, 32'h100, 5, 7, "add", mk(6'h01, 5, 7, 3, 1, 0, 0, 0, 32'h104, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        chkv("rs1_field", 32'(b0.in_rs1), 32'd1);
        chkv("rs2_field", 32'(b0.in_rs2), 32'd2);
        chkv("add_latency", 32'(b0.out_valid), 32'd1);

        // back-to-back stream, each cycle retires the previous instruction
        set(32'h4040D093, 32'h104, 32'h80000000, 32'h11, "srai",
            mk(6'h34, 32'h80000000, 32'h404, 1, 1, 0, 0, 0, 32'h108, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h0020F863, 32'hFFFFFFF8, 3, 4, "bgeu_wrap",
            mk(6'h1F, 3, 4, 16, 0, 3, 0, 32'h8, 32'hFFFFFFFC, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'hFFC32283, 32'h200, 32'h1000, 32'h22, "lw",
            mk(6'h00, 32'h1000, 32'hFFFFFFFC, 5, 1, 1, 0, 0, 32'h204, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h00732423, 32'h204, 32'h1000, 32'hDEADBEEF, "sw",
            mk(6'h00, 32'h1000, 32'h8, 8, 0, 2, 32'hDEADBEEF, 0, 32'h208, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'hABCDE537, 32'h300, 32'h55, 32'h66, "lui",
            mk(6'h00, 0, 32'hABCDE000, 10, 1, 0, 0, 0, 32'h304, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'hABCDE517, 32'h300, 32'h55, 32'h66, "auipc",
            mk(6'h00, 32'h300, 32'hABCDE000, 10, 1, 0, 0, 0, 32'h304, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'hFF9FF0EF, 32'h10, 0, 0, "jal",
            mk(6'h00, 0, 0, 1, 1, 4, 0, 32'h8, 32'h14, 0), jal_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h00008067, 32'h20, 32'h1235, 0, "jalr_x0",
            mk(6'h00, 32'h1235, 0, 0, 0, 4, 0, 0, 32'h24, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h402081B3, 32'h40, 10, 3, "sub",
            mk(6'h21, 10, 3, 3, 1, 0, 0, 0, 32'h44, 0), all_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h40209133, 32'h44, 0, 0, "ill_op_f7", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ill_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h0020A063, 32'h48, 0, 0, "ill_branch", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ill_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h40109093, 32'h4C, 0, 0, "ill_slli", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ill_m);
        cyc(1'b1, 1'b1, 1'b0, 1);
        set(32'h0000007F, 32'h50, 0, 0, "ill_opcode", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ill_m);
        cyc(1'b1, 1'b1, 1'b0, 1);

        // MUL: illegal without M, MULDIV with M
        set(32'h023100B3, 32'h50, 6, 7, "mul", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ill_m);
        nxt.chk1 = 1'b1;
        nxt.e1   = mk(6'h00, 6, 7, 1, 1, 5, 0, 0, 32'h54, 0);
        cyc(1'b1, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, -1);

        // stall three cycles with a pending input
        set(32'hABCDE537, 32'h300, 0, 0, "stall_head",
            mk(6'h00, 0, 32'hABCDE000, 10, 1, 0, 0, 0, 32'h304, 0), all_m);
        cyc(1'b1, 1'b0, 1'b0, 1);
        snap = cur0();
        set(32'h002081B3, 32'h100, 8, 9, "stall_tail", mk(6'h01, 8, 9, 3, 1, 0, 0, 0, 32'h104, 0), all_m);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0);
            chk("stall_stable", cur0(), snap);
            chkv("stall_valid", 32'(b0.out_valid), 32'd1);
        end
        cyc(1'b1, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, -1);

        // flush while stalled: held entry dropped, pending input taken next cycle
        set(32'h002081B3, 32'h100, 1, 2, "flushed", mk(6'h01, 1, 2, 3, 1, 0, 0, 0, 32'h104, 0), all_m);
        cyc(1'b1, 1'b0, 1'b0, 1);
        set(32'h4040D093, 32'h104, 32'hF0, 0, "after_flush",
            mk(6'h34, 32'hF0, 32'h404, 1, 1, 0, 0, 0, 32'h108, 0), all_m);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chkv("flush_valid", 32'(b0.out_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, -1);

        // reset mid-stall drops the held instruction
        set(32'h002081B3, 32'h100, 1, 2, "rst_drop", mk(6'h01, 1, 2, 3, 1, 0, 0, 0, 32'h104, 0), all_m);
        cyc(1'b1, 1'b0, 1'b0, 1);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        sbq.delete();
        chkv("rst_stall_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_stall_outputs", cur0(), '0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, -1);

        chkv("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ENABLE_RV32_M, default 0; 1 = accept RV32M encodings, 0 = flag them illegal.
REQ-002 SHALL have port clk, input, 1; the single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1; instruction word valid.
REQ-005 SHALL have port in_ready, output, 1; stage accepts the instruction this cycle.
REQ-006 SHALL have ports in_instr, in_pc, in_rs1_data and in_rs2_data, each input, 32 bits; the register-file data is combinationally valid alongside in_instr.
REQ-007 SHALL have ports in_rs1 and in_rs2, each output, 5 bits; equal to in_instr[19:15] and in_instr[24:20], combinational.
REQ-008 SHALL have port flush, input, 1; discard the held instruction.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1).
REQ-010 SHALL have output out_S, 6 bits; the ALU select.
REQ-011 SHALL have outputs out_A and out_B, each 32 bits; the ALU operands.
REQ-012 SHALL have output out_rd, 5 bits, and output out_wb, 1 bit; out_wb = write rd.
REQ-013 SHALL have output out_kind, 3 bits: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 MULDIV.
REQ-014 SHALL have outputs out_store_data, out_target and out_link, each 32 bits; out_target = branch/JAL target, out_link = pc+4.
REQ-015 SHALL have output out_illegal, 1 bit.

Function
REQ-016 SHALL be a single-entry output register: in_ready = !out_valid || out_ready; a transfer occurs when in_valid && in_ready.
REQ-017 SHALL on transfer set out_valid=1 and load all out_* from the decoded instruction; with out_valid && !out_ready, all outputs SHALL hold stable.
REQ-018 SHALL clear out_valid when out_valid && out_ready and there is no new transfer.
REQ-019 SHALL give flush priority: out_valid=0 next cycle and in_ready=0 in the flush cycle, so the input is not consumed.
REQ-020 SHALL, for OP (0110011) with funct7 in {0000000, 0100000}, drive S = {funct7[5], funct3, 1'b0, funct3==000}, A=rs1, B=rs2, kind ALU; funct7[5]=1 is legal only for funct3 000/101.
REQ-021 SHALL, for OP-IMM (0010011), drive S = {funct3==101 && funct7[5], funct3, 2'b00}, A=rs1, B=sext(imm_I).
REQ-022 SHALL mark OP-IMM illegal for funct3 001 with funct7 != 0000000, and for funct3 101 with funct7 not in {0000000, 0100000}.
REQ-023 SHALL, for BRANCH (1100011), drive S = {1'b0, funct3, 2'b11}, A=rs1, B=rs2, out_wb=0, target = pc+sext(imm_B); funct3 010/011 are illegal.
REQ-024 SHALL, for LOAD, drive S=000000, A=rs1, B=sext(imm_I), kind LOAD.
REQ-025 SHALL, for STORE, drive S=000000, A=rs1, B=sext(imm_S), store_data=rs2, wb=0.
REQ-026 SHALL, for LUI, drive S=000000, A=0, B={imm[31:12], 12'b0}; for AUIPC, the same except A=pc.
REQ-027 SHALL, for JAL, drive kind JUMP, target = pc+sext(imm_J), link = pc+4, wb=1.
REQ-028 SHALL, for JALR, drive kind JUMP, S=000000, A=rs1, B=sext(imm_I), link = pc+4, wb=1; the consumer clears bit 0 of the target.
REQ-029 SHALL, for OP with funct7 0000001: when ENABLE_RV32_M=1, drive kind MULDIV, S = {funct3, 3'b000}, A=rs1, B=rs2; otherwise flag illegal.
REQ-030 SHALL force out_wb=0 when rd=0 or the instruction is illegal; illegal instructions still transfer, with out_illegal=1.
REQ-031 SHALL treat every other opcode as illegal.
REQ-032 SHALL compute all address/immediate sums modulo 2^32 (wrap-around, no flag).

Reset
REQ-033 SHALL on rst set out_valid=0 and out_illegal=0, and clear all other registered outputs to 0; rst overrides flush and transfer.
REQ-034 SHALL drive in_ready=0 in a rst cycle; a rst mid-stall drops the held instruction.

Verification
REQ-035 SHALL be checked with: ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> S=000001, A=5, B=7, rd=3, wb=1, one cycle latency.
REQ-036 SHALL be checked with: SRAI x1,x1,4 (0x4040D093) -> S=110100, B=0x00000404 (the consumer uses B[4:0]).
REQ-037 SHALL be checked with: BGEU at pc=0xFFFFFFF8 with offset +16 -> S=011111, target=0x00000008 (wrap), wb=0.
REQ-038 SHALL be checked with: out_ready=0 for 3 cycles while in_valid=1 -> outputs stable, in_ready=0, no instruction lost or duplicated.
REQ-039 SHALL be checked with: flush while stalled -> out_valid=0 next cycle, pending input accepted on the following cycle.
REQ-040 SHALL be checked with: MUL x1,x2,x3 (0x023100B3), ENABLE_RV32_M=0 -> illegal=1, wb=0; with ENABLE_RV32_M=1 -> kind=5.
